light_conflict_monitor: RTL and testbench

// Watchdog on the light-output side of the two-approach traffic light controller.
// It samples the 6-bit lamp bus every cycle and checks it for conflicting

---
 rtl/light_conflict_monitor_if.sv | 12 +
 rtl/light_conflict_monitor.sv | 155 +++++++++++++++
 tb/tb_light_conflict_monitor.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/light_conflict_monitor_if.sv
// Lamp-bus monitor port bundle: controller lamps and clear in, fault status and sanitised lamps out.
interface light_conflict_monitor_if;
  logic [5:0] l;
  logic       fault_clr;
  logic       fault;
  logic [2:0] fault_code;
  logic [5:0] l_safe;
  logic [1:0] mon_state;

  modport master (output l, fault_clr, input fault, fault_code, l_safe, mon_state);
  modport slave  (input l, fault_clr, output fault, fault_code, l_safe, mon_state);
endinterface

// File: rtl/light_conflict_monitor.sv
// Lamp-bus watchdog: latches the first conflict/sequence fault (1-cycle latency), then forces flashing red.
// No backpressure: the lamp bus is sampled every cycle and l_safe is combinational from l and state.
module light_conflict_monitor #(
  parameter int MIN_YELLOW = 2,
  parameter int MAX_DARK   = 3,
  parameter int FLASH_DIV  = 4,
  parameter int CW         = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  light_conflict_monitor_if.slave mon
);

  typedef enum logic [1:0] {S_INIT = 2'd0, S_RUN = 2'd1, S_TRIP = 2'd2} state_e;

  localparam logic [1:0]    C_G        = 2'd0;
  localparam logic [1:0]    C_Y        = 2'd1;
  localparam logic [1:0]    C_R        = 2'd2;
  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [CW-1:0] MIN_Y_C    = CW'(MIN_YELLOW);
  localparam logic [CW-1:0] MAX_DARK_C = CW'(MAX_DARK);
  localparam logic [CW-1:0] FLASH_LAST = CW'(FLASH_DIV - 1);

  state_e              state_q, state_d;
  logic                fault_q, fault_d;
  logic [2:0]          code_q, code_d;
  logic [1:0][1:0]     last_q, last_d;
  logic [1:0][CW-1:0]  dark_q, dark_d;
  logic [1:0][CW-1:0]  yel_q, yel_d;
  logic [CW-1:0]       flash_q, flash_d;
  logic                ph_q, ph_d;

  // Index 1 is approach A (l[5:3]), index 0 is approach B (l[2:0]).
  logic [1:0][2:0]     lamp;
  logic [1:0]          dark, multi, perm, now_g, now_y, now_r;
  logic [1:0]          dark_hit, gy_skip, short_y, bad_seq;
  logic [2:0]          hit_code;

  always_comb begin
    lamp     = mon.l;
    dark     = '0;
    multi    = '0;
    perm     = '0;
    now_g    = '0;
    now_y    = '0;
    now_r    = '0;
    dark_hit = '0;
    gy_skip  = '0;
    short_y  = '0;
    bad_seq  = '0;
    dark_d   = dark_q;
    yel_d    = yel_q;
    last_d   = last_q;
    state_d  = state_q;
    fault_d  = fault_q;
    code_d   = code_q;
    flash_d  = flash_q;
    ph_d     = ph_q;
    hit_code = 3'd0;

    for (int i = 0; i < 2; i++) begin
      dark[i]     = (lamp[i] == 3'b000);
      multi[i]    = ((lamp[i] & (lamp[i] - 3'd1)) != 3'b000);
      perm[i]     = lamp[i][2] | lamp[i][1];
      now_g[i]    = (lamp[i] == 3'b100);
      now_y[i]    = (lamp[i] == 3'b010);
      now_r[i]    = (lamp[i] == 3'b001);
      dark_hit[i] = dark[i] && (dark_q[i] >= MAX_DARK_C);
      gy_skip[i]  = (last_q[i] == C_G) && now_r[i];
      short_y[i]  = (last_q[i] == C_Y) && now_r[i] && (yel_q[i] < MIN_Y_C);
      bad_seq[i]  = ((last_q[i] == C_Y) && now_g[i]) || ((last_q[i] == C_R) && now_y[i]);

      if (dark[i]) dark_d[i] = (dark_q[i] == CNT_MAX) ? dark_q[i] : dark_q[i] + 1'b1;
      else         dark_d[i] = '0;

      // Dark and multi samples leave both the yellow count and the last colour alone.
      if (now_y[i])                 yel_d[i] = (yel_q[i] == CNT_MAX) ? yel_q[i] : yel_q[i] + 1'b1;
      else if (now_g[i] || now_r[i]) yel_d[i] = '0;

      if (now_g[i])      last_d[i] = C_G;
      else if (now_y[i]) last_d[i] = C_Y;
      else if (now_r[i]) last_d[i] = C_R;
    end

    if (&perm)          hit_code = 3'd1;
    else if (|multi)    hit_code = 3'd2;
    else if (|dark_hit) hit_code = 3'd3;
    else if (state_q == S_RUN) begin
      if (|gy_skip)      hit_code = 3'd4;
      else if (|short_y) hit_code = 3'd5;
      else if (|bad_seq) hit_code = 3'd6;
    end

    case (state_q)
      S_TRIP: begin
        dark_d = dark_q;
        yel_d  = yel_q;
        last_d = last_q;
        if (flash_q == FLASH_LAST) begin
          flash_d = '0;
          ph_d    = ~ph_q;
        end else begin
          flash_d = flash_q + 1'b1;
        end
        if (mon.fault_clr) begin
          state_d = S_INIT;
          fault_d = 1'b0;
          code_d  = 3'd0;
          dark_d  = '0;
          yel_d   = '0;
          last_d  = {C_R, C_R};
          flash_d = '0;
          ph_d    = 1'b1;
        end
      end
      default: begin
        if (hit_code != 3'd0) begin
          state_d = S_TRIP;
          fault_d = 1'b1;
          code_d  = hit_code;
        end else begin
          state_d = S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      fault_q <= 1'b0;
      code_q  <= 3'd0;
      last_q  <= {C_R, C_R};
      dark_q  <= '0;
      yel_q   <= '0;
      flash_q <= '0;
      ph_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      last_q  <= last_d;
      dark_q  <= dark_d;
      yel_q   <= yel_d;
      flash_q <= flash_d;
      ph_q    <= ph_d;
    end
  end

  assign mon.fault      = fault_q;
  assign mon.fault_code = code_q;
  assign mon.mon_state  = state_q;
  assign mon.l_safe     = (state_q == S_TRIP) ? {2'b00, ph_q, 2'b00, ph_q} : mon.l;

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Directed bench for light_conflict_monitor: expectations queued per step, checked after the clock edge.
module tb_light_conflict_monitor;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;
  int   step_no;

  light_conflict_monitor_if mif ();

  light_conflict_monitor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       f;
    logic [2:0] c;
    logic [1:0] s;
    logic [5:0] ls;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL step %0d %s: got %0h expected %0h", step_no, name, obs, exp);
  endtask

  task automatic push(input logic ef, input logic [2:0] ec, input logic [1:0] es, input logic [5:0] els);
    exp_t e;
    e.f = ef; e.c = ec; e.s = es; e.ls = els;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_total++;
      $error("FAIL step %0d scoreboard: got empty queue expected an entry", step_no);
    end else begin
      e = sb.pop_front();
      chk("fault",      8'(mif.fault),      8'(e.f));
      chk("fault_code", 8'(mif.fault_code), 8'(e.c));
      chk("mon_state",  8'(mif.mon_state),  8'(e.s));
      chk("l_safe",     8'(mif.l_safe),     8'(e.ls));
    end
  endtask

  task automatic step(input logic [5:0] lv, input logic clr, input logic ef, input logic [2:0] ec,
                      input logic [1:0] es, input logic [5:0] els);
    mif.l         = lv;
    mif.fault_clr = clr;
    push(ef, ec, es, els);
    @(posedge clk);
    #1;
    step_no++;
    pop_check();
  endtask

  task automatic run_ok(input logic [5:0] lv);
    step(lv, 1'b0, 1'b0, 3'd0, 2'd1, lv);
  endtask

  task automatic trip(input logic [5:0] lv, input logic [2:0] code, input logic ph);
    step(lv, 1'b0, 1'b1, code, 2'd2, {2'b00, ph, 2'b00, ph});
  endtask

  task automatic clear(input logic [5:0] lv);
    step(lv, 1'b1, 1'b0, 3'd0, 2'd0, lv);
  endtask

  initial begin
    n_total       = 0;
    n_pass        = 0;
    step_no       = 0;
    rst_n         = 1'b0;
    mif.l         = 6'b001_001;
    mif.fault_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push(1'b0, 3'd0, 2'd0, 6'b001_001);
    pop_check();
    rst_n = 1'b1;

    // Legal cycle on A then on B
    repeat (3) run_ok(6'b100_001);
    repeat (2) run_ok(6'b010_001);
    run_ok(6'b001_001);
    run_ok(6'b001_100);
    repeat (2) run_ok(6'b001_010);
    run_ok(6'b001_001);

    // Conflict, then flash timing; a second violation in TRIP must not change the code
    trip(6'b100_100, 3'd1, 1'b1);
    repeat (3) trip(6'b001_001, 3'd1, 1'b1);
    trip(6'b100_100, 3'd1, 1'b0);
    repeat (3) trip(6'b001_001, 3'd1, 1'b0);
    trip(6'b001_001, 3'd1, 1'b1);

    // Clear from TRIP goes through INIT to RUN; clear in RUN is ignored
    clear(6'b001_001);
    run_ok(6'b001_001);
    step(6'b001_001, 1'b1, 1'b0, 3'd0, 2'd1, 6'b001_001);

    // Short yellow, then a yellow of exactly the minimum length
    run_ok(6'b100_001);
    run_ok(6'b010_001);
    trip(6'b001_001, 3'd5, 1'b1);
    clear(6'b001_001);
    run_ok(6'b001_001);
    run_ok(6'b100_001);
    repeat (2) run_ok(6'b010_001);
    run_ok(6'b001_001);

    // Multi on B wins over G->R skip on A in the same edge
    run_ok(6'b100_001);
    trip(6'b001_110, 3'd2, 1'b1);
    clear(6'b001_001);
    run_ok(6'b001_001);

    // Dark for MAX_DARK cycles is tolerated; one more trips
    repeat (3) run_ok(6'b000_001);
    run_ok(6'b100_001);
    repeat (3) run_ok(6'b000_001);
    trip(6'b000_001, 3'd3, 1'b1);
    clear(6'b001_001);
    run_ok(6'b001_001);

    // Green straight to red
    run_ok(6'b100_001);
    trip(6'b001_001, 3'd4, 1'b1);
    clear(6'b001_001);
    run_ok(6'b001_001);

    // Yellow back to green
    run_ok(6'b100_001);
    run_ok(6'b010_001);
    trip(6'b100_001, 3'd6, 1'b1);
    trip(6'b001_001, 3'd6, 1'b1);

    // Asynchronous reset mid-TRIP, observed before any clock edge
    #3;
    rst_n = 1'b0;
    #1;
    step_no++;
    push(1'b0, 3'd0, 2'd0, 6'b001_001);
    pop_check();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    chk("sb_drained", 8'(sb.size()), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
